spi_pixel_deserializer: RTL and testbench

//  Consumes the phase-aligned serial bit stream from data_select (data_in_buff plus a one-cycle sample strobe).

---
 rtl/spi_pixel_deserializer_pkg.sv | 17 +
 rtl/spi_pixel_deserializer_if.sv | 47 ++++
 rtl/spi_pixel_deserializer_fifo.sv | 53 +++++
 rtl/spi_pixel_deserializer.sv | 175 +++++++++++++++++
 tb/tb_spi_pixel_deserializer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pixel_deserializer_pkg.sv
// Shared types and constants for the SPI pixel deserializer.
package spi_pixel_deserializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    SHIFT,
    DROP
  } deser_state_t;

  localparam int unsigned FRAME_W           = 320;
  localparam int unsigned FRAME_H           = 240;
  localparam int unsigned DESER_WORD_W      = 8;
  // 1-bit pixels packed DESER_WORD_W per word
  localparam int unsigned DESER_FRAME_WORDS = FRAME_W * FRAME_H / DESER_WORD_W;

endpackage

// File: rtl/spi_pixel_deserializer_if.sv
// Bit-stream input, pixel-word output and error-flag bundle of the deserializer.
// Optional feature macro: SPI_DESER_WORD_ADDR_EN adds the word_addr sideband.
interface spi_pixel_deserializer_if
  import spi_pixel_deserializer_pkg::*;
#(
  parameter int unsigned WORD_W = DESER_WORD_W,
  parameter int unsigned ADDR_W = 14
);

  logic              cal_done;
  logic              SPI_cs_n;
  logic              bit_in;
  logic              bit_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_sof;
  logic              word_valid;
  logic              word_ready;
  logic              overflow;
  logic              trunc_err;
  logic              err_clr;
`ifdef SPI_DESER_WORD_ADDR_EN
  logic [ADDR_W-1:0] word_addr;

  // Stimulus / consumer side
  modport master (
    output cal_done, SPI_cs_n, bit_in, bit_valid, word_ready, err_clr,
    input  word_data, word_sof, word_valid, overflow, trunc_err, word_addr
  );

  // Deserializer side
  modport slave (
    input  cal_done, SPI_cs_n, bit_in, bit_valid, word_ready, err_clr,
    output word_data, word_sof, word_valid, overflow, trunc_err, word_addr
  );
`else
  modport master (
    output cal_done, SPI_cs_n, bit_in, bit_valid, word_ready, err_clr,
    input  word_data, word_sof, word_valid, overflow, trunc_err
  );

  modport slave (
    input  cal_done, SPI_cs_n, bit_in, bit_valid, word_ready, err_clr,
    output word_data, word_sof, word_valid, overflow, trunc_err
  );
`endif

endinterface

// File: rtl/spi_pixel_deserializer_fifo.sv
// deser_fifo: single-clock first-word-fall-through FIFO. Full/empty come from
// pointers carrying one extra wrap bit. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module deser_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DWIDTH = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DWIDTH-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW:0]     wptr_q, wptr_d;
  logic [PtrW:0]     rptr_q, rptr_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic              wr_ok, rd_ok;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                     (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign rd_ok     = rd_en_i && !empty_o;
  assign wr_ok     = wr_en_i && (!full_o || rd_ok);
  assign rd_data_o = mem_q[rptr_q[PtrW-1:0]];

  // Pointer advance
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
  end

  // Pointer and storage registers; storage is cleared so the head reads 0 after reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (wr_ok) mem_q[wptr_q[PtrW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/spi_pixel_deserializer.sv
// Frames the sampled serial stream by chip-select, packs bits MSB-first into
// pixel words, tags the first word of each frame and buffers words in a FWFT
// FIFO. Overflow and truncated words raise sticky flags cleared by err_clr.
// Optional feature macro: SPI_DESER_WORD_ADDR_EN adds a frame-relative word_addr.
module spi_pixel_deserializer
  import spi_pixel_deserializer_pkg::*;
#(
  parameter int unsigned WORD_W      = DESER_WORD_W,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned FRAME_WORDS = DESER_FRAME_WORDS
) (
  input logic                     CLK_40,
  input logic                     reset,
  spi_pixel_deserializer_if.slave deser_io
);

  localparam int unsigned CntW = $clog2(WORD_W);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (FRAME_WORDS < 2 || WORD_W < 2) begin : g_bad_frame
    $error("FRAME_WORDS and WORD_W must be at least 2");
  end

`ifdef SPI_DESER_WORD_ADDR_EN
  localparam int unsigned ADDR_W = $clog2(FRAME_WORDS);
  localparam int unsigned FifoW  = ADDR_W + 1 + WORD_W;
`else
  localparam int unsigned FifoW  = 1 + WORD_W;
`endif

  deser_state_t    state_q, state_d;
  logic            cs_q;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic            sof_pending_q, sof_pending_d;
  logic            overflow_q, overflow_d;
  logic            trunc_q, trunc_d;

  logic              push_req, ovf_set, trunc_set, frame_start;
  logic              fifo_full, fifo_empty, pop;
  logic [WORD_W-1:0] word_in;
  logic [FifoW-1:0]  fifo_wdata, fifo_rdata;

  assign word_in = {shreg_q[WORD_W-2:0], deser_io.bit_in};
  assign pop     = deser_io.word_ready && !fifo_empty;

  // FSM next state, shift register, bit counter and error flag updates
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    sof_pending_d = sof_pending_q;
    push_req      = 1'b0;
    ovf_set       = 1'b0;
    trunc_set     = 1'b0;
    frame_start   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (deser_io.cal_done) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        // Only a genuine high-to-low transition starts a frame
        if (cs_q && !deser_io.SPI_cs_n) begin
          bit_cnt_d     = '0;
          sof_pending_d = 1'b1;
          frame_start   = 1'b1;
          state_d       = SHIFT;
        end
      end
      SHIFT: begin
        if (deser_io.SPI_cs_n) begin
          trunc_set = (bit_cnt_q != '0);
          bit_cnt_d = '0;
          state_d   = WAIT_FRAME;
        end else if (deser_io.bit_valid) begin
          shreg_d = word_in;
          if (bit_cnt_q == CntW'(WORD_W - 1)) begin
            push_req      = 1'b1;
            bit_cnt_d     = '0;
            sof_pending_d = 1'b0;
            if (fifo_full && !pop) begin
              ovf_set = 1'b1;
              state_d = DROP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      DROP: begin
        if (deser_io.SPI_cs_n) state_d = WAIT_FRAME;
      end
      default: state_d = IDLE;
    endcase

    // Losing calibration aborts framing from any state; buffered words survive
    if (!deser_io.cal_done) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end
  end

  // Sticky flags: a new event beats a simultaneous clear
  assign overflow_d = (overflow_q && !deser_io.err_clr) || ovf_set;
  assign trunc_d    = (trunc_q && !deser_io.err_clr) || trunc_set;

  // State and datapath registers
  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cs_q          <= 1'b0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      sof_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
      trunc_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cs_q          <= deser_io.SPI_cs_n;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      sof_pending_q <= sof_pending_d;
      overflow_q    <= overflow_d;
      trunc_q       <= trunc_d;
    end
  end

`ifdef SPI_DESER_WORD_ADDR_EN
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Frame-relative word index; dropped words still consume an index
  always_comb begin
    addr_d = addr_q;
    if (frame_start) begin
      addr_d = '0;
    end else if (push_req) begin
      addr_d = (addr_q == ADDR_W'(FRAME_WORDS - 1)) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  // Word index register
  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  assign fifo_wdata = {addr_q, sof_pending_q, word_in};
  assign {deser_io.word_addr, deser_io.word_sof, deser_io.word_data} = fifo_rdata;
`else
  assign fifo_wdata = {sof_pending_q, word_in};
  assign {deser_io.word_sof, deser_io.word_data} = fifo_rdata;
`endif

  deser_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DWIDTH(FifoW)
  ) u_fifo (
    .clk_i    (CLK_40),
    .rst_i    (reset),
    .wr_en_i  (push_req && !ovf_set),
    .wr_data_i(fifo_wdata),
    .rd_en_i  (pop),
    .rd_data_o(fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign deser_io.word_valid = !fifo_empty;
  assign deser_io.overflow   = overflow_q;
  assign deser_io.trunc_err  = trunc_q;

endmodule

// File: tb/tb_spi_pixel_deserializer.sv
// Bench for spi_pixel_deserializer: directed scenarios plus randomized frames,
// all outputs compared every cycle against a frame/word-level model.
module tb_spi_pixel_deserializer;
  import spi_pixel_deserializer_pkg::*;

  localparam int unsigned WW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FW    = 9600;
  localparam int unsigned AW    = $clog2(FW);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_pixel_deserializer_if #(.WORD_W(WW), .ADDR_W(AW)) bus ();

  spi_pixel_deserializer #(
    .WORD_W     (WW),
    .FIFO_DEPTH (DEPTH),
    .FRAME_WORDS(FW)
  ) dut (
    .CLK_40  (clk),
    .reset   (rst),
    .deser_io(bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          sof;
    logic [WW-1:0] data;
  } entry_t;

  entry_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Model: words expected at the output, and the framing status of the stream
  bit m_active, m_sof, m_ovf, m_trunc, rand_rdy;
  int m_n, m_acc, m_addr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_active = 0; m_sof = 0; m_ovf = 0; m_trunc = 0;
    m_n = 0; m_acc = 0; m_addr = 0;
  endtask

  // One clock: compare outputs, apply this cycle's events to the model, advance
  task automatic cycle(input bit push, input bit trunc_ev, input bit clr);
    bit pop;
    if (rand_rdy) bus.word_ready = 1'($urandom_range(0, 1));
    bus.err_clr = clr;
    check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
    check_eq("trunc_err", 32'(bus.trunc_err), 32'(m_trunc));
    check_eq("word_valid", 32'(bus.word_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_eq("word_data", 32'(bus.word_data), 32'(exp_q[0].data));
      check_eq("word_sof", 32'(bus.word_sof), 32'(exp_q[0].sof));
`ifdef SPI_DESER_WORD_ADDR_EN
      check_eq("word_addr", 32'(bus.word_addr), 32'(exp_q[0].addr));
`endif
    end
    pop = (exp_q.size() != 0) && bus.word_ready;
    if (pop) exp_q.delete(0);
    if (clr) begin
      m_ovf = 0;
      m_trunc = 0;
    end
    if (trunc_ev) m_trunc = 1;
    if (push) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back('{addr: AW'(m_addr), sof: m_sof, data: WW'(m_acc)});
      end else begin
        m_ovf = 1;
        m_active = 0;
      end
      m_sof = 0;
      m_acc = 0;
      m_addr = (m_addr == FW - 1) ? 0 : m_addr + 1;
    end
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.bit_valid = 1'b0;
      bus.bit_in = 1'($urandom);
      cycle(0, 0, 0);
    end
  endtask

  task automatic send_bit(input bit b);
    bit push = 0;
    bus.bit_in = b;
    bus.bit_valid = 1'b1;
    if (m_active) begin
      m_acc = m_acc * 2 + int'(b);
      m_n++;
      if (m_n == WW) begin
        push = 1;
        m_n = 0;
      end
    end
    cycle(push, 0, 0);
    bus.bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int gap_max);
    logic [WW-1:0] v;
    v = w;
    for (int i = WW - 1; i >= 0; i--) begin
      send_bit(v[i]);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic start_frame();
    bus.SPI_cs_n = 1'b1;
    idle(2);
    bus.SPI_cs_n = 1'b0;
    m_active = 1; m_n = 0; m_sof = 1; m_acc = 0; m_addr = 0;
    cycle(0, 0, 0);
    idle(1);
  endtask

  task automatic end_frame();
    bit tr;
    bus.SPI_cs_n = 1'b1;
    tr = m_active && (m_n != 0);
    m_active = 0; m_n = 0; m_acc = 0;
    cycle(0, tr, 0);
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    bus.cal_done = 1'b0;
    bus.SPI_cs_n = 1'b1;
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;
    bus.word_ready = 1'b0;
    bus.err_clr = 1'b0;
    rand_rdy = 0;
    model_reset();
    #12;
    check_eq("rst_valid", 32'(bus.word_valid), 0);
    check_eq("rst_data", 32'(bus.word_data), 0);
    check_eq("rst_sof", 32'(bus.word_sof), 0);
    check_eq("rst_overflow", 32'(bus.overflow), 0);
    check_eq("rst_trunc", 32'(bus.trunc_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single word B2, held while not ready
    bus.cal_done = 1'b1;
    cycle(0, 0, 0);
    start_frame();
    send_word(8'hB2, 0);
    check_eq("t1_valid_latency", 32'(bus.word_valid), 1);
    idle(2);
    bus.word_ready = 1'b1;
    idle(2);
    end_frame();

    // 2: three words in one frame, consumer always ready
    start_frame();
    send_word(8'hA5, 0);
    send_word(8'h3C, 1);
    send_word(8'hFF, 0);
    end_frame();
    idle(3);

    // 3: overflow with a stalled consumer, then recovery and clear
    bus.word_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 6; i++) send_word(8'($urandom), 0);
    end_frame();
    bus.word_ready = 1'b1;
    start_frame();
    send_word(8'h69, 0);
    end_frame();
    idle(6);
    cycle(0, 0, 1);
    idle(1);

    // 4: truncated word, then a correctly aligned frame
    start_frame();
    send_bit(1); send_bit(0); send_bit(1);
    end_frame();
    start_frame();
    send_word(8'h5A, 0);
    end_frame();
    idle(2);
    cycle(0, 0, 1);

    // 5: push and pop in the same cycle while full
    bus.word_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 4; i++) send_word(8'($urandom), 0);
    for (int i = 0; i < 7; i++) send_bit(1'($urandom));
    bus.word_ready = 1'b1;
    send_bit(1);
    bus.word_ready = 1'b0;
    idle(2);
    end_frame();
    bus.word_ready = 1'b1;
    idle(6);

    // calibration loss mid-frame: no resync until a fresh falling edge
    start_frame();
    send_bit(0); send_bit(1); send_bit(1);
    bus.cal_done = 1'b0;
    m_active = 0; m_n = 0; m_acc = 0;
    cycle(0, 0, 0);
    bus.cal_done = 1'b1;
    send_word(8'hC3, 0);
    end_frame();
    start_frame();
    send_word(8'h81, 0);
    end_frame();

    // randomized frames
    rand_rdy = 1;
    for (int f = 0; f < 25; f++) begin
      start_frame();
      for (int w = 0; w < $urandom_range(1, 6); w++) send_word(8'($urandom), 2);
      if ($urandom_range(0, 3) == 0) begin
        for (int b = 0; b < $urandom_range(1, 7); b++) send_bit(1'($urandom));
      end
      end_frame();
      idle($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) cycle(0, 0, 1);
    end
    rand_rdy = 0;

    // asynchronous reset in the middle of a word
    bus.word_ready = 1'b0;
    start_frame();
    send_word(8'h96, 0);
    send_word(8'h17, 0);
    send_bit(1); send_bit(1); send_bit(0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(bus.word_valid), 0);
    check_eq("arst_data", 32'(bus.word_data), 0);
    check_eq("arst_sof", 32'(bus.word_sof), 0);
    check_eq("arst_overflow", 32'(bus.overflow), 0);
    check_eq("arst_trunc", 32'(bus.trunc_err), 0);
    model_reset();
    bus.SPI_cs_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.word_ready = 1'b1;
    idle(2);
    start_frame();
    send_word(8'h4E, 1);
    end_frame();
    idle(3);

`ifdef SPI_DESER_WORD_ADDR_EN
    // address wrap across a frame longer than FRAME_WORDS, then restart
    start_frame();
    for (int i = 0; i < FW + 1; i++) send_word(8'($urandom), 0);
    end_frame();
    start_frame();
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    end_frame();
    idle(3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
